// File: rtl/add_issue_sched_pkg.sv
// Shared types for the add/sub/branch issue scheduler.
// Latency: n/a (types, constants and a pure age helper only).
// Backpressure: n/a.
//
// Contents:
//   N_ENTRIES, ROB_W, XLEN  sizing constants shared by scheduler and bench
//   add_rs_entry_t          reservation-station payload {rs1, rs2, rob, ALUop, load, branch_type}
//   add_sched_state_t       scheduler FSM states
//   rob_age()               distance of a ROB tag from rob_head, mod 2**ROB_W
package add_issue_sched_pkg;

    localparam int N_ENTRIES = 4;
    localparam int ROB_W     = 4;
    localparam int XLEN      = 32;

    typedef struct packed {
        logic [XLEN-1:0]  rs1;
        logic [XLEN-1:0]  rs2;
        logic [ROB_W-1:0] rob;
        logic             ALUop;
        logic             load;
        logic [1:0]       branch_type;
    } add_rs_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } add_sched_state_t;

    // Unsigned modular distance from the ROB head: 0 is the oldest in flight.
    function automatic logic [ROB_W-1:0] rob_age(input logic [ROB_W-1:0] tag,
                                                 input logic [ROB_W-1:0] head);
        return tag - head;
    endfunction

endpackage

// File: rtl/add_issue_sched_age_select.sv
// Oldest-ready picker: one-hot winner among requesting entries by ROB age.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the winner is consumed.
//
// Ports:
//   req        in   N_ENTRIES           entries eligible this cycle
//   tags       in   N_ENTRIES x ROB_W   ROB tag of each entry
//   head       in   ROB_W               current ROB head
//   winner     out  N_ENTRIES           one-hot oldest requester (0 when none)
//   any_valid  out  1                   at least one entry is requesting
module add_issue_sched_age_select
    import add_issue_sched_pkg::*;
(
    input  logic [N_ENTRIES-1:0]            req,
    input  logic [N_ENTRIES-1:0][ROB_W-1:0] tags,
    input  logic [ROB_W-1:0]                head,
    output logic [N_ENTRIES-1:0]            winner,
    output logic                            any_valid
);

    logic [ROB_W-1:0] best_age;
    logic [ROB_W-1:0] age;
    logic             found;

    // Linear scan with a strict less-than: on an (illegal) age tie the
    // lower index is kept.
    always_comb begin
        winner   = '0;
        best_age = '1;
        age      = '0;
        found    = 1'b0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            age = rob_age(tags[i], head);
            if (req[i] && (!found || (age < best_age))) begin
                winner    = '0;
                winner[i] = 1'b1;
                best_age  = age;
                found     = 1'b1;
            end
        end
    end

    assign any_valid = |req;

endmodule

// File: rtl/add_issue_sched.sv
// Issue scheduler: grants the oldest ready add RS entry and drives one valid_in pulse into the unit.
// Latency: grant at t, fu_valid_in at t+1; next grant at yumi+1 (or at yumi with ADD_ISSUE_BYPASS_EN).
// Backpressure: holds in BUSY until cdb_yumi drains the unit; no grant while ISSUE/BUSY.
//
// Optional feature macro: ADD_ISSUE_BYPASS_EN -- grant again in the yumi cycle for 2-cycle issue.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   entry_req         per-entry ready request
//   entries           per-entry payload (add_rs_entry_t)
//   rob_head          oldest in-flight ROB tag
//   flush             mispredict squash (kills a pending ISSUE, ignored in BUSY)
//   cdb_yumi          CDB accepted the unit's result
//   grant             one-hot, single-cycle; RS frees that entry
//   fu_valid_in, fu_rs1, fu_rs2, fu_rob_entry, fu_ALUop, fu_load, fu_branch_type
//                     issue bundle into the functional unit
//   fu_busy           scheduler not idle
module add_issue_sched
    import add_issue_sched_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_ENTRIES-1:0]          entry_req,
    input  add_rs_entry_t [N_ENTRIES-1:0] entries,
    input  logic [ROB_W-1:0]              rob_head,
    input  logic                          flush,
    input  logic                          cdb_yumi,
    output logic [N_ENTRIES-1:0]          grant,
    output logic                          fu_valid_in,
    output logic [XLEN-1:0]               fu_rs1,
    output logic [XLEN-1:0]               fu_rs2,
    output logic [ROB_W-1:0]              fu_rob_entry,
    output logic                          fu_ALUop,
    output logic                          fu_load,
    output logic [1:0]                    fu_branch_type,
    output logic                          fu_busy
);

    add_sched_state_t                state;
    add_rs_entry_t                   payload_q;
    add_rs_entry_t                   win_entry;
    logic [N_ENTRIES-1:0]            winner;
    logic                            any_valid;
    logic [N_ENTRIES-1:0][ROB_W-1:0] tags;
    logic                            issue_slot;
    logic                            issue_now;

    always_comb begin
        tags = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            tags[i] = entries[i].rob;
        end
    end

    add_issue_sched_age_select u_age_select (
        .req       (entry_req),
        .tags      (tags),
        .head      (rob_head),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // The bypass slot is safe: the unit is drained by yumi at the edge that
    // also moves us into ISSUE, so the new valid_in lands one cycle after yumi.
`ifdef ADD_ISSUE_BYPASS_EN
    assign issue_slot = (state == IDLE) || ((state == BUSY) && cdb_yumi);
`else
    assign issue_slot = (state == IDLE);
`endif

    // Grant is decided in the same cycle the RS presents its requests, so the
    // RS can free the entry at the following edge; reset and flush veto it.
    assign issue_now = issue_slot && any_valid && !flush && !reset;
    assign grant     = issue_now ? winner : '0;

    // winner is one-hot (or zero), so a priority mux is exact.
    always_comb begin
        win_entry = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (winner[i]) begin
                win_entry = entries[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            payload_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (issue_now) begin
                        state     <= ISSUE;
                        payload_q <= win_entry;
                    end
                end
                ISSUE: begin
                    // A flush squashes the granted op before the unit sees it.
                    state <= flush ? IDLE : BUSY;
                end
                BUSY: begin
                    // flush is deliberately ignored: the unit must drain via yumi.
                    if (cdb_yumi) begin
                        if (issue_now) begin
                            state     <= ISSUE;
                            payload_q <= win_entry;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Payload registers only change on a grant; fu_valid_in qualifies them.
    assign fu_valid_in    = (state == ISSUE) && !flush && !reset;
    assign fu_rs1         = payload_q.rs1;
    assign fu_rs2         = payload_q.rs2;
    assign fu_rob_entry   = payload_q.rob;
    assign fu_ALUop       = payload_q.ALUop;
    assign fu_load        = payload_q.load;
    assign fu_branch_type = payload_q.branch_type;
    assign fu_busy        = (state != IDLE);

endmodule

// File: tb/tb_add_issue_sched.sv
// Directed self-checking bench for add_issue_sched.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
// Expectations follow the bypass macro when it is defined for the build.
module tb_add_issue_sched;
    import add_issue_sched_pkg::*;

`ifdef ADD_ISSUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                          clk;
    logic                          reset;
    logic [N_ENTRIES-1:0]          entry_req;
    add_rs_entry_t [N_ENTRIES-1:0] entries;
    logic [ROB_W-1:0]              rob_head;
    logic                          flush;
    logic                          cdb_yumi;
    logic [N_ENTRIES-1:0]          grant;
    logic                          fu_valid_in;
    logic [XLEN-1:0]               fu_rs1;
    logic [XLEN-1:0]               fu_rs2;
    logic [ROB_W-1:0]              fu_rob_entry;
    logic                          fu_ALUop;
    logic                          fu_load;
    logic [1:0]                    fu_branch_type;
    logic                          fu_busy;

    int n_checks = 0;
    int n_fail   = 0;

    add_issue_sched dut (
        .clk            (clk),
        .reset          (reset),
        .entry_req      (entry_req),
        .entries        (entries),
        .rob_head       (rob_head),
        .flush          (flush),
        .cdb_yumi       (cdb_yumi),
        .grant          (grant),
        .fu_valid_in    (fu_valid_in),
        .fu_rs1         (fu_rs1),
        .fu_rs2         (fu_rs2),
        .fu_rob_entry   (fu_rob_entry),
        .fu_ALUop       (fu_ALUop),
        .fu_load        (fu_load),
        .fu_branch_type (fu_branch_type),
        .fu_busy        (fu_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic add_rs_entry_t mk(input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                                         input logic [ROB_W-1:0] rob, input logic aluop,
                                         input logic load, input logic [1:0] bt);
        add_rs_entry_t e;
        e.rs1         = rs1;
        e.rs2         = rs2;
        e.rob         = rob;
        e.ALUop       = aluop;
        e.load        = load;
        e.branch_type = bt;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; entry_req = '0; flush = 1'b0; cdb_yumi = 1'b0;
        rob_head = '0; entries = '0;
        step(); step();
        #1;
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL rst_grant: got %b want 0000", grant); end
        n_checks++; if (fu_valid_in !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", fu_valid_in); end
        n_checks++; if (fu_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", fu_busy); end
        n_checks++; if (fu_rs1 !== 32'h0) begin n_fail++; $display("FAIL rst_rs1: got %h want 0", fu_rs1); end
        n_checks++; if (fu_rob_entry !== 4'h0) begin n_fail++; $display("FAIL rst_rob: got %h want 0", fu_rob_entry); end
        entry_req = 4'b0001;
        #1;
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL rst_grant_held: got %b want 0000", grant); end
        entry_req = '0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_single();
        entries[0] = mk(32'h1111_0001, 32'h2222_0001, 4'd3, 1'b1, 1'b0, 2'b01);
        rob_head = 4'd0; entry_req = 4'b0001;
        #1;
        n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL t1_grant: got %b want 0001", grant); end
        n_checks++; if (fu_valid_in !== 1'b0) begin n_fail++; $display("FAIL t1_valid_t: got %b want 0", fu_valid_in); end
        step(); entry_req = '0; #1;
        n_checks++; if (fu_valid_in !== 1'b1) begin n_fail++; $display("FAIL t1_valid_t1: got %b want 1", fu_valid_in); end
        n_checks++; if (fu_rob_entry !== 4'd3) begin n_fail++; $display("FAIL t1_rob: got %0d want 3", fu_rob_entry); end
        n_checks++; if (fu_rs1 !== 32'h1111_0001) begin n_fail++; $display("FAIL t1_rs1: got %h want 11110001", fu_rs1); end
        n_checks++; if (fu_ALUop !== 1'b1) begin n_fail++; $display("FAIL t1_aluop: got %b want 1", fu_ALUop); end
        n_checks++; if (fu_branch_type !== 2'b01) begin n_fail++; $display("FAIL t1_bt: got %b want 01", fu_branch_type); end
        n_checks++; if (fu_busy !== 1'b1) begin n_fail++; $display("FAIL t1_busy_issue: got %b want 1", fu_busy); end
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL t1_grant_issue: got %b want 0000", grant); end
        step(); #1;
        n_checks++; if (fu_valid_in !== 1'b0) begin n_fail++; $display("FAIL t1_valid_busy: got %b want 0", fu_valid_in); end
        n_checks++; if (fu_busy !== 1'b1) begin n_fail++; $display("FAIL t1_busy: got %b want 1", fu_busy); end
        n_checks++; if (fu_rob_entry !== 4'd3) begin n_fail++; $display("FAIL t1_rob_hold: got %0d want 3", fu_rob_entry); end
        step(); #1;
        n_checks++; if (fu_busy !== 1'b1) begin n_fail++; $display("FAIL t1_busy_wait: got %b want 1", fu_busy); end
        cdb_yumi = 1'b1;
        step(); cdb_yumi = 1'b0; #1;
        n_checks++; if (fu_busy !== 1'b0) begin n_fail++; $display("FAIL t1_idle_after_yumi: got %b want 0", fu_busy); end
    endtask

    task automatic test_oldest();
        entries[0] = mk(32'h9999_0001, 32'h9999_0002, 4'd9, 1'b0, 1'b0, 2'b00);
        entries[1] = mk(32'h5555_0001, 32'h5555_0002, 4'd5, 1'b0, 1'b1, 2'b10);
        entries[2] = mk(32'h4444_0001, 32'h4444_0002, 4'd4, 1'b0, 1'b0, 2'b00);
        entries[3] = mk(32'h7777_0001, 32'h7777_0002, 4'd7, 1'b0, 1'b0, 2'b00);
        rob_head = 4'd4; entry_req = 4'b1011;
        #1;
        n_checks++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL t2_grant: got %b want 0010", grant); end
        step(); entry_req = '0; #1;
        n_checks++; if (fu_valid_in !== 1'b1) begin n_fail++; $display("FAIL t2_valid: got %b want 1", fu_valid_in); end
        n_checks++; if (fu_rs1 !== 32'h5555_0001) begin n_fail++; $display("FAIL t2_rs1: got %h want 55550001", fu_rs1); end
        n_checks++; if (fu_rs2 !== 32'h5555_0002) begin n_fail++; $display("FAIL t2_rs2: got %h want 55550002", fu_rs2); end
        n_checks++; if (fu_rob_entry !== 4'd5) begin n_fail++; $display("FAIL t2_rob: got %0d want 5", fu_rob_entry); end
        n_checks++; if (fu_load !== 1'b1) begin n_fail++; $display("FAIL t2_load: got %b want 1", fu_load); end
        n_checks++; if (fu_branch_type !== 2'b10) begin n_fail++; $display("FAIL t2_bt: got %b want 10", fu_branch_type); end
        step(); cdb_yumi = 1'b1; #1;
        n_checks++; if (fu_valid_in !== 1'b0) begin n_fail++; $display("FAIL t2_valid_yumi: got %b want 0", fu_valid_in); end
        step(); cdb_yumi = 1'b0; #1;
        n_checks++; if (fu_busy !== 1'b0) begin n_fail++; $display("FAIL t2_idle: got %b want 0", fu_busy); end
    endtask

    task automatic test_wrap();
        entries[0] = mk(32'hAAAA_0001, 32'hAAAA_0002, 4'd1,  1'b0, 1'b0, 2'b00);
        entries[2] = mk(32'hCCCC_0001, 32'hCCCC_0002, 4'd15, 1'b1, 1'b0, 2'b11);
        rob_head = 4'd14; entry_req = 4'b0101;
        #1;
        n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL t3_grant: got %b want 0100", grant); end
        step(); entry_req = '0; #1;
        n_checks++; if (fu_rob_entry !== 4'd15) begin n_fail++; $display("FAIL t3_rob: got %0d want 15", fu_rob_entry); end
        n_checks++; if (fu_rs1 !== 32'hCCCC_0001) begin n_fail++; $display("FAIL t3_rs1: got %h want cccc0001", fu_rs1); end
        step(); cdb_yumi = 1'b1;
        step(); cdb_yumi = 1'b0; #1;
        n_checks++; if (fu_busy !== 1'b0) begin n_fail++; $display("FAIL t3_idle: got %b want 0", fu_busy); end
    endtask

    task automatic test_back_to_back();
        entries[0] = mk(32'hE000_0001, 32'hE000_0002, 4'd2, 1'b0, 1'b0, 2'b00);
        rob_head = 4'd0; entry_req = 4'b0001;
        #1;
        n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL t4_grant0: got %b want 0001", grant); end
        step(); #1;
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL t4_grant_issue: got %b want 0000", grant); end
        n_checks++; if (fu_valid_in !== 1'b1) begin n_fail++; $display("FAIL t4_valid0: got %b want 1", fu_valid_in); end
        step(); #1;
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL t4_grant_busy: got %b want 0000", grant); end
        cdb_yumi = 1'b1; #1;
        n_checks++; if (fu_valid_in !== 1'b0) begin n_fail++; $display("FAIL t4_valid_at_yumi: got %b want 0", fu_valid_in); end
        n_checks++; if (grant !== (BYP ? 4'b0001 : 4'b0000)) begin n_fail++; $display("FAIL t4_grant_t: got %b want %b", grant, (BYP ? 4'b0001 : 4'b0000)); end
        step(); cdb_yumi = 1'b0; #1;
        n_checks++; if (grant !== (BYP ? 4'b0000 : 4'b0001)) begin n_fail++; $display("FAIL t4_grant_t1: got %b want %b", grant, (BYP ? 4'b0000 : 4'b0001)); end
        n_checks++; if (fu_valid_in !== BYP) begin n_fail++; $display("FAIL t4_valid_t1: got %b want %b", fu_valid_in, BYP); end
        step(); #1;
        n_checks++; if (fu_valid_in !== !BYP) begin n_fail++; $display("FAIL t4_valid_t2: got %b want %b", fu_valid_in, !BYP); end
        entry_req = '0;
        step(); #1;
        n_checks++; if (fu_busy !== 1'b1) begin n_fail++; $display("FAIL t4_busy2: got %b want 1", fu_busy); end
        cdb_yumi = 1'b1;
        step(); cdb_yumi = 1'b0; #1;
        n_checks++; if (fu_busy !== 1'b0) begin n_fail++; $display("FAIL t4_idle: got %b want 0", fu_busy); end
    endtask

    task automatic test_flush();
        entries[1] = mk(32'hF000_0001, 32'hF000_0002, 4'd6, 1'b0, 1'b0, 2'b00);
        rob_head = 4'd0; flush = 1'b1; entry_req = 4'b0010;
        #1;
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL t5_grant_flush_idle: got %b want 0000", grant); end
        flush = 1'b0; #1;
        n_checks++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL t5_grant: got %b want 0010", grant); end
        step(); entry_req = '0; flush = 1'b1; #1;
        n_checks++; if (fu_valid_in !== 1'b0) begin n_fail++; $display("FAIL t5_valid_flushed: got %b want 0", fu_valid_in); end
        step(); flush = 1'b0; #1;
        n_checks++; if (fu_busy !== 1'b0) begin n_fail++; $display("FAIL t5_idle_after_flush: got %b want 0", fu_busy); end
        entry_req = 4'b0010; #1;
        step(); entry_req = '0; #1;
        n_checks++; if (fu_valid_in !== 1'b1) begin n_fail++; $display("FAIL t5_valid_reissue: got %b want 1", fu_valid_in); end
        step(); flush = 1'b1; entry_req = 4'b0010; #1;
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL t5_grant_busy: got %b want 0000", grant); end
        step(); #1;
        n_checks++; if (fu_busy !== 1'b1) begin n_fail++; $display("FAIL t5_busy_flush: got %b want 1", fu_busy); end
        flush = 1'b0; entry_req = '0; cdb_yumi = 1'b1;
        step(); cdb_yumi = 1'b0; #1;
        n_checks++; if (fu_busy !== 1'b0) begin n_fail++; $display("FAIL t5_idle: got %b want 0", fu_busy); end
    endtask

    task automatic test_reset_busy();
        entries[3] = mk(32'hD000_0001, 32'hD000_0002, 4'd8, 1'b1, 1'b1, 2'b11);
        rob_head = 4'd0; entry_req = 4'b1000;
        #1;
        n_checks++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL t6_grant0: got %b want 1000", grant); end
        step(); entry_req = '0;
        step(); #1;
        n_checks++; if (fu_busy !== 1'b1) begin n_fail++; $display("FAIL t6_busy: got %b want 1", fu_busy); end
        reset = 1'b1;
        step(); reset = 1'b0; #1;
        n_checks++; if (fu_busy !== 1'b0) begin n_fail++; $display("FAIL t6_busy_rst: got %b want 0", fu_busy); end
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL t6_grant_rst: got %b want 0000", grant); end
        n_checks++; if (fu_valid_in !== 1'b0) begin n_fail++; $display("FAIL t6_valid_rst: got %b want 0", fu_valid_in); end
        n_checks++; if (fu_rs1 !== 32'h0) begin n_fail++; $display("FAIL t6_rs1_rst: got %h want 0", fu_rs1); end
        step(); entry_req = 4'b1000; #1;
        n_checks++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL t6_grant_new: got %b want 1000", grant); end
        step(); entry_req = '0; #1;
        n_checks++; if (fu_valid_in !== 1'b1) begin n_fail++; $display("FAIL t6_valid_new: got %b want 1", fu_valid_in); end
        n_checks++; if (fu_rob_entry !== 4'd8) begin n_fail++; $display("FAIL t6_rob_new: got %0d want 8", fu_rob_entry); end
        step(); cdb_yumi = 1'b1;
        step(); cdb_yumi = 1'b0; #1;
        n_checks++; if (fu_busy !== 1'b0) begin n_fail++; $display("FAIL t6_idle: got %b want 0", fu_busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_oldest();
        test_wrap();
        test_back_to_back();
        test_flush();
        test_reset_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
